// File: rtl/sweep_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sweep_seq_pkg : shared types and constants for sweep_seq_ctrl     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package sweep_seq_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    SETTLE = 4'd2,
    MEAS   = 4'd3,
    WAIT   = 4'd4,
    WR_MOD = 4'd5,
    WR_PHS = 4'd6,
    NEXT   = 4'd7,
    DONE   = 4'd8
  } state_t;

  // Sliced down to DATA_WIDTH by the user.
  localparam logic [127:0] SENTINEL = '1;

  localparam logic SEL_MOD = 1'b0;
  localparam logic SEL_PHS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sweep_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sweep_seq_ctrl_if : control, measurement and result-buffer bundle |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface sweep_seq_ctrl_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SETTLE_WIDTH = 16
);
  logic                    start;
  logic                    abort;
  logic [ADDR_WIDTH:0]     cfg_npts;
  logic [SETTLE_WIDTH-1:0] cfg_settle;
  logic [31:0]             cfg_timeout;
  logic [ADDR_WIDTH-1:0]   freq_addr;
  logic                    freq_load;
  logic                    meas_start;
  logic                    meas_valid;
  logic [DATA_WIDTH-1:0]   meas_mod;
  logic [DATA_WIDTH-1:0]   meas_phs;
  logic                    res_we;
  logic [ADDR_WIDTH:0]     res_addr;
  logic [DATA_WIDTH-1:0]   res_wdata;
  logic                    busy;
  logic                    done;
  logic                    timeout;
  logic [ADDR_WIDTH-1:0]   pnt_idx;

  // Controller side
  modport master (
    input  start, abort, cfg_npts, cfg_settle, cfg_timeout,
    input  meas_valid, meas_mod, meas_phs,
    output freq_addr, freq_load, meas_start,
    output res_we, res_addr, res_wdata,
    output busy, done, timeout, pnt_idx
  );

  // Host / measurement / buffer side
  modport slave (
    output start, abort, cfg_npts, cfg_settle, cfg_timeout,
    output meas_valid, meas_mod, meas_phs,
    input  freq_addr, freq_load, meas_start,
    input  res_we, res_addr, res_wdata,
    input  busy, done, timeout, pnt_idx
  );
endinterface
`default_nettype wire

// File: rtl/sweep_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sweep_seq_ctrl : frequency-sweep sequencer (load/settle/measure/  |
// | store per point). Optional macro SWEEP_SEQ_TIMEOUT_EN enables the |
// | measurement timeout. Rev 1.0                                      |
// +------------------------------------------------------------------+
module sweep_seq_ctrl
  import sweep_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SETTLE_WIDTH = 16
) (
  input  wire                    dac_clk_i,
  input  wire                    dac_rstn_i,
  input  wire                    start_i,
  input  wire                    abort_i,
  input  wire [ADDR_WIDTH:0]     cfg_npts_i,
  input  wire [SETTLE_WIDTH-1:0] cfg_settle_i,
  input  wire [31:0]             cfg_timeout_i,
  output logic [ADDR_WIDTH-1:0]  freq_addr_o,
  output logic                   freq_load_o,
  output logic                   meas_start_o,
  input  wire                    meas_valid_i,
  input  wire [DATA_WIDTH-1:0]   meas_mod_i,
  input  wire [DATA_WIDTH-1:0]   meas_phs_i,
  output logic                   res_we_o,
  output logic [ADDR_WIDTH:0]    res_addr_o,
  output logic [DATA_WIDTH-1:0]  res_wdata_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [ADDR_WIDTH-1:0]  pnt_idx_o
);

`ifdef SWEEP_SEQ_TIMEOUT_EN
  localparam int CNT_W = (SETTLE_WIDTH > 32) ? SETTLE_WIDTH : 32;
`else
  localparam int CNT_W = SETTLE_WIDTH;
`endif

  state_t                  state, next;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   last_idx;
  logic [SETTLE_WIDTH-1:0] settle_val;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   mod_cap;
  logic [DATA_WIDTH-1:0]   phs_cap;
  logic                    freq_load_q, meas_start_q, res_we_q, done_q;
  logic                    wait_expired;
  logic                    tmo_hit;
  logic [ADDR_WIDTH:0]     npts_m1;

  // Any count with the top bit set is 2^ADDR_WIDTH or more, so it clamps to all points.
  assign npts_m1 = cfg_npts_i - (ADDR_WIDTH+1)'(1);

`ifdef SWEEP_SEQ_TIMEOUT_EN
  logic [31:0] tmo_val;
  logic        timeout_q;
  assign wait_expired = (cnt == '0);
  assign timeout_o    = timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo   = ^cfg_timeout_i;
  assign wait_expired = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_comb begin
    next    = state;
    tmo_hit = 1'b0;
    if (state != IDLE && abort_i) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE:   if (start_i && cfg_npts_i != '0) next = LOAD;
        LOAD:   next = SETTLE;
        SETTLE: if (cnt == '0) next = MEAS;
        MEAS:   next = WAIT;
        WAIT: begin
          if (meas_valid_i) begin
            next = WR_MOD;
          end else if (wait_expired) begin
            next    = WR_MOD;
            tmo_hit = 1'b1;
          end
        end
        WR_MOD: next = WR_PHS;
        WR_PHS: next = NEXT;
        NEXT:   next = (idx == last_idx) ? DONE : LOAD;
        DONE:   next = IDLE;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state        <= IDLE;
      idx          <= '0;
      last_idx     <= '0;
      settle_val   <= '0;
      cnt          <= '0;
      mod_cap      <= '0;
      phs_cap      <= '0;
      freq_load_q  <= 1'b0;
      meas_start_q <= 1'b0;
      res_we_q     <= 1'b0;
      done_q       <= 1'b0;
`ifdef SWEEP_SEQ_TIMEOUT_EN
      tmo_val      <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state        <= next;
      // Strobes follow the state being entered, so they are flops aligned with it.
      freq_load_q  <= (next == LOAD);
      meas_start_q <= (next == MEAS);
      res_we_q     <= (next == WR_MOD) || (next == WR_PHS);
      done_q       <= (next == DONE);
      case (state)
        IDLE: begin
          if (next == LOAD) begin
            last_idx   <= cfg_npts_i[ADDR_WIDTH] ? '1 : npts_m1[ADDR_WIDTH-1:0];
            settle_val <= cfg_settle_i;
            idx        <= '0;
`ifdef SWEEP_SEQ_TIMEOUT_EN
            tmo_val    <= cfg_timeout_i;
            timeout_q  <= 1'b0;
`endif
          end
        end
        LOAD:   cnt <= CNT_W'(settle_val);
        SETTLE: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        MEAS: begin
`ifdef SWEEP_SEQ_TIMEOUT_EN
          cnt <= CNT_W'(tmo_val);
`else
          cnt <= '0;
`endif
        end
        WAIT: begin
          if (next == WR_MOD) begin
            if (tmo_hit) begin
              mod_cap <= SENTINEL[DATA_WIDTH-1:0];
              phs_cap <= SENTINEL[DATA_WIDTH-1:0];
`ifdef SWEEP_SEQ_TIMEOUT_EN
              timeout_q <= 1'b1;
`endif
            end else begin
              mod_cap <= meas_mod_i;
              phs_cap <= meas_phs_i;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        NEXT: if (next == LOAD) idx <= idx + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  assign freq_load_o  = freq_load_q;
  assign meas_start_o = meas_start_q;
  assign res_we_o     = res_we_q;
  assign done_o       = done_q;
  assign busy_o       = (state != IDLE);
  assign freq_addr_o  = idx;
  assign pnt_idx_o    = idx;
  assign res_addr_o   = {(state == WR_PHS) ? SEL_PHS : SEL_MOD, idx};
  assign res_wdata_o  = (state == WR_PHS) ? phs_cap : mod_cap;

endmodule
`default_nettype wire

// File: tb/tb_sweep_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sweep_seq_ctrl : cycle-timeline model bench for sweep_seq_ctrl |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_sweep_seq_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sweep_seq_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_WIDTH(SW)) bus ();

  sweep_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_WIDTH(SW)) dut (
    .dac_clk_i    (clk),
    .dac_rstn_i   (rstn),
    .start_i      (bus.start),
    .abort_i      (bus.abort),
    .cfg_npts_i   (bus.cfg_npts),
    .cfg_settle_i (bus.cfg_settle),
    .cfg_timeout_i(bus.cfg_timeout),
    .freq_addr_o  (bus.freq_addr),
    .freq_load_o  (bus.freq_load),
    .meas_start_o (bus.meas_start),
    .meas_valid_i (bus.meas_valid),
    .meas_mod_i   (bus.meas_mod),
    .meas_phs_i   (bus.meas_phs),
    .res_we_o     (bus.res_we),
    .res_addr_o   (bus.res_addr),
    .res_wdata_o  (bus.res_wdata),
    .busy_o       (bus.busy),
    .done_o       (bus.done),
    .timeout_o    (bus.timeout),
    .pnt_idx_o    (bus.pnt_idx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] mod_of(input int p);
    return 32'h1000_0000 + 32'(p) * 32'h0001_0003;
  endfunction
  function automatic logic [31:0] phs_of(input int p);
    return 32'h8000_0000 ^ (32'(p) << 4);
  endfunction

  // Expected timeline, keyed by absolute cycle number
  int          load_addr[int];
  bit          meas_at[int];
  int          we_addr[int];
  logic [31:0] we_data[int];
  bit          done_at[int];
  bit          valid_at[int];
  bit          stray_at[int];
  logic [31:0] vmod[int];
  logic [31:0] vphs[int];
  int          abort_cyc, win_lo, win_hi, busy_end, tmo_cyc;
  bit          started, tmo_prev, chk;

  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_load[$], obs_meas[$], obs_done[$];

  function automatic bit exp_tmo(input int c);
    bit t;
    t = started ? (c >= tmo_cyc) : tmo_prev;
`ifndef SWEEP_SEQ_TIMEOUT_EN
    t = 1'b0;
`endif
    return t;
  endfunction

  // Per point: LOAD at L, measurement start after the settle cycles, the
  // two writes follow the valid (or expiry) cycle, next LOAD 4 cycles later.
  task automatic plan(input int s, input int npts, input int settle, input int dly,
                      input int tmo, input bit use_tmo, input int abort_pt);
    int n, l, m, v;
    load_addr.delete(); meas_at.delete(); we_addr.delete(); we_data.delete();
    done_at.delete(); valid_at.delete(); stray_at.delete(); vmod.delete(); vphs.delete();
    abort_cyc = -1;
    n        = (npts > 256) ? 256 : npts;
    started  = (n > 0);
    tmo_cyc  = 1 << 30;
    win_lo   = s + 1;
    busy_end = s;
    l        = s + 1;
    for (int p = 0; p < n; p++) begin
      m = l + settle + 2;
      v = use_tmo ? (m + tmo + 1) : (m + dly);
      load_addr[l] = p;
      meas_at[m]   = 1'b1;
      if (p == abort_pt) begin
        abort_cyc = m + 1;
        valid_at[m+1] = 1'b1;
        vmod[m+1] = mod_of(p);
        vphs[m+1] = phs_of(p);
        busy_end = m + 1;
        break;
      end
      if (!use_tmo) begin
        valid_at[v] = 1'b1;
        vmod[v] = mod_of(p);
        vphs[v] = phs_of(p);
        if (dly >= 2) stray_at[m] = 1'b1;
      end else if (tmo_cyc > v + 1) begin
        tmo_cyc = v + 1;
      end
      we_addr[v+1] = p;
      we_data[v+1] = use_tmo ? 32'hFFFF_FFFF : mod_of(p);
      we_addr[v+2] = 256 + p;
      we_data[v+2] = use_tmo ? 32'hFFFF_FFFF : phs_of(p);
      l = v + 4;
      if (p == n - 1) begin
        done_at[v+4] = 1'b1;
        busy_end = v + 4;
      end
    end
    win_hi = (busy_end > s) ? busy_end + 3 : s + 5;
  endtask

  int cmp_c;
  always @(negedge clk) begin
    if (chk && cyc >= win_lo && cyc <= win_hi) begin
      cmp_c = cyc;
      check("freq_load", bus.freq_load, load_addr.exists(cmp_c));
      if (load_addr.exists(cmp_c)) begin
        check("freq_addr", bus.freq_addr, load_addr[cmp_c]);
        check("pnt_idx", bus.pnt_idx, load_addr[cmp_c]);
      end
      check("meas_start", bus.meas_start, meas_at.exists(cmp_c));
      check("res_we", bus.res_we, we_addr.exists(cmp_c));
      if (we_addr.exists(cmp_c)) begin
        check("res_addr", bus.res_addr, we_addr[cmp_c]);
        check("res_wdata", bus.res_wdata, we_data[cmp_c]);
      end
      check("done", bus.done, done_at.exists(cmp_c));
      check("busy", bus.busy, (cmp_c >= win_lo) && (cmp_c <= busy_end));
      check("timeout", bus.timeout, exp_tmo(cmp_c));
    end
    if (chk) begin
      if (bus.res_we) begin
        obs_addr.push_back(int'(bus.res_addr));
        obs_data.push_back(bus.res_wdata);
      end
      if (bus.freq_load)  obs_load.push_back(cyc);
      if (bus.meas_start) obs_meas.push_back(cyc);
      if (bus.done)       obs_done.push_back(cyc);
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.meas_valid = 1'b0;
    bus.meas_mod = '0; bus.meas_phs = '0;
  endtask

  task automatic run(input int npts, input int settle, input int dly, input int tmo,
                     input bit use_tmo, input int abort_pt, input int extra_start);
    int s;
    s = cyc;
    plan(s, npts, settle, dly, tmo, use_tmo, abort_pt);
    obs_addr.delete(); obs_data.delete(); obs_load.delete(); obs_meas.delete(); obs_done.delete();
    chk = 1'b1;
    for (int c = s; c <= win_hi; c++) begin
      // Config is scrambled after the start cycle; the DUT must use latched values.
      bus.cfg_npts    = (c == s) ? 9'(npts) : 9'd1;
      bus.cfg_settle  = (c == s) ? 16'(settle) : 16'(settle + 7);
      bus.cfg_timeout = (c == s) ? (use_tmo ? 32'(tmo) : 32'd1000) : 32'd2;
      bus.start       = (c == s) || (extra_start > 0 && c == s + extra_start);
      bus.abort       = (c == abort_cyc);
      bus.meas_valid  = valid_at.exists(c) || stray_at.exists(c);
      bus.meas_mod    = valid_at.exists(c) ? vmod[c] : 32'hDEAD_0000 + 32'(c);
      bus.meas_phs    = valid_at.exists(c) ? vphs[c] : 32'hBEEF_0000 + 32'(c);
      @(posedge clk); #1;
    end
    idle_inputs();
    chk = 1'b0;
    tmo_prev = exp_tmo(win_hi);
  endtask

  int ones;
  initial begin
    idle_inputs();
    bus.cfg_npts = '0; bus.cfg_settle = '0; bus.cfg_timeout = '0;
    chk = 1'b0; tmo_prev = 1'b0; started = 1'b0;
    win_lo = 0; win_hi = -1; busy_end = -1; tmo_cyc = 1 << 30; abort_cyc = -1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_strobes", {bus.freq_load, bus.meas_start, bus.res_we, bus.done}, 4'b0000);
    check("rst_timeout", bus.timeout, 1'b0);
    check("rst_res_addr", bus.res_addr, 9'h000);
    check("rst_res_wdata", bus.res_wdata, 32'h0);
    check("rst_idx", bus.pnt_idx, 8'h00);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // 3 points, settle 2, valid 4 cycles after each meas_start, stray start mid-sweep
    run(3, 2, 4, 0, 1'b0, -1, 7);
    check("n3_writes", obs_addr.size(), 6);
    if (obs_addr.size() == 6) begin
      check("n3_a0", obs_addr[0], 32'h000); check("n3_a1", obs_addr[1], 32'h100);
      check("n3_a2", obs_addr[2], 32'h001); check("n3_a3", obs_addr[3], 32'h101);
      check("n3_a4", obs_addr[4], 32'h002); check("n3_a5", obs_addr[5], 32'h102);
      check("n3_d0", obs_data[0], 32'h1000_0000);
      check("n3_d5", obs_data[5], 32'h8000_0020);
    end
    check("n3_done_cnt", obs_done.size(), 1);

    // settle 0, single point: load->meas 2 cycles, valid 3 later, done 4 after valid
    run(1, 0, 3, 0, 1'b0, -1, 0);
    if (obs_load.size() == 1 && obs_meas.size() == 1 && obs_done.size() == 1) begin
      check("s0_load_to_meas", obs_meas[0] - obs_load[0], 2);
      check("s0_valid_to_done", obs_done[0] - (obs_meas[0] + 3), 4);
    end else begin
      check("s0_pulse_counts", {obs_load.size(), obs_meas.size()}, {32'd1, 32'd1});
    end

    // start with zero points does nothing
    run(0, 0, 1, 0, 1'b0, -1, 0);
    check("n0_loads", obs_load.size(), 0);

    // abort in WAIT of point 1 of 4, same cycle as a valid
    run(4, 1, 1, 0, 1'b0, 1, 0);
    check("abort_writes", obs_addr.size(), 2);
    ones = 0;
    foreach (obs_addr[i]) if ((obs_addr[i] & 32'hFF) == 1) ones++;
    check("abort_idx1_writes", ones, 0);
    check("abort_done_cnt", obs_done.size(), 0);

`ifdef SWEEP_SEQ_TIMEOUT_EN
    run(1, 1, 0, 10, 1'b1, -1, 0);
    check("tmo_writes", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      check("tmo_a0", obs_addr[0], 32'h000); check("tmo_a1", obs_addr[1], 32'h100);
      check("tmo_d0", obs_data[0], 32'hFFFF_FFFF);
    end
    check("tmo_done_cnt", obs_done.size(), 1);
    @(negedge clk);
    check("tmo_sticky", bus.timeout, 1'b1);
    @(posedge clk); #1;
    run(2, 0, 0, 0, 1'b1, -1, 0);
    check("tmo0_writes", obs_addr.size(), 4);
`endif

    // 0x1FF points clamps to 256
    run(32'h1FF, 0, 1, 0, 1'b0, -1, 0);
    check("clamp_writes", obs_addr.size(), 512);
    if (obs_addr.size() == 512) begin
      check("clamp_last", obs_addr[511], 32'h1FF);
      check("clamp_prev", obs_addr[510], 32'h0FF);
    end
    check("clamp_loads", obs_load.size(), 256);
    check("clamp_done_cnt", obs_done.size(), 1);

    // reset during SETTLE, then restart
    bus.cfg_npts = 9'd2; bus.cfg_settle = 16'd6; bus.cfg_timeout = 32'd1000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstmid_busy", bus.busy, 1'b0);
      check("rstmid_we", bus.res_we, 1'b0);
      check("rstmid_timeout", bus.timeout, 1'b0);
      check("rstmid_idx", bus.pnt_idx, 8'h00);
    end
    @(posedge clk); #1;
    tmo_prev = 1'b0;
    run(2, 1, 2, 0, 1'b0, -1, 0);
    if (obs_addr.size() > 0) check("rstmid_first_addr", obs_addr[0], 32'h000);
    else check("rstmid_first_addr_missing", obs_addr.size(), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
